mux_gate_arbiter: RTL and testbench
===================================

Name: mux_gate_arbiter

Overview:
- Shares one mux-built bitwise logic unit among N_REQ requesters.
- Each requester submits an opcode and two W-bit operands over a valid/ready handshake.
- A round-robin arbiter grants one request per cycle. The selected operation is evaluated by the shared mux-based gate unit, registered, and returned with the requester id over a valid/ready response port.
- Sits between the lab's gate-from-mux primitives and any client that needs time-shared logic evaluation.

Parameters:
N_REQ, 4, number of requesters (2..8)
W, 8, operand/result width in bits
IDW, $clog2(N_REQ), requester id width (derived, not overridden)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  N_REQ  bit i: requester i has a request
req_ready  out  N_REQ  bit i: request i accepted this cycle (one-hot or zero)
req_op  in  3*N_REQ  opcode of requester i at bits [3i+2:3i]
req_a  in  W*N_REQ  operand a of requester i at bits [W*i+W-1:W*i]
req_b  in  W*N_REQ  operand b of requester i, same packing
rsp_valid  out  1  response register holds a result
rsp_ready  in  1  consumer accepts response
rsp_id  out  IDW  index of requester that produced rsp_data
rsp_data  out  W  result
grant_cnt  out  16  total accepted requests, saturates at 16'hFFFF

Behaviour:
- Reset (async assert, sync-safe deassert): rsp_valid=0, rsp_id=0, rsp_data=0, grant_cnt=0, rr pointer=0.
- Reset mid-operation discards any held response. No response is emitted for it.
- Opcodes, all bitwise over W bits: 0 AND, 1 OR, 2 NOT a (b ignored), 3 XOR, 4 NAND, 5 NOR, 6 XNOR, 7 BUF a.
- Exactly one shared gate-unit instance, built from 2:1 mux primitives. Its result equals the reference expression for every input.
- Output register is a 2-state FSM:
  - EMPTY (rsp_valid=0)
  - FULL (rsp_valid=1)
- can_accept = EMPTY, or FULL with rsp_ready=1.
- Arbitration (combinational):
  - When can_accept, grant the lowest index k ≥ ptr (circular, wrapping N_REQ-1 → 0) with req_valid[k]=1.
  - req_ready[k]=1 for that index only.
  - When !can_accept or no valid request, req_ready=0.
- On accept (req_valid[k] & req_ready[k]), at the next edge:
  - rsp_data = op(a_k, b_k)
  - rsp_id = k
  - rsp_valid = 1
  - ptr = (k+1) mod N_REQ
  - grant_cnt += 1, unless already 16'hFFFF
- Latency: accept cycle + 1.
- Throughput: 1 transaction per cycle while rsp_ready=1.
- FULL, rsp_ready=1, with a request: drain and reload happen in the same edge. rsp_valid stays 1 with the new data.
- FULL, rsp_ready=1, no request: next state EMPTY. rsp_data/rsp_id hold their last values.
- FULL, rsp_ready=0 (backpressure): rsp_valid, rsp_id, rsp_data held stable. req_ready all 0. ptr unchanged.
- ptr changes only on an accept. Idle cycles do not advance it.
- Requester handshake rules:
  - Requesters must hold valid and payload until ready.
  - The block may assert ready in the same cycle valid rises.
  - req_ready depends combinationally on req_valid and rsp_ready. There is no combinational path from req_op/a/b to any ready.
- Fairness: under continuous requests from all N_REQ, every requester is granted once per N_REQ accepts.

Test Plan:
- Reset then idle, rst_n low 3 cycles → rsp_valid=0, rsp_data=0, grant_cnt=0, req_ready=0. Assert rst_n low while FULL → rsp_valid falls immediately, without waiting for clk.
- Opcode sweep, single requester 0, W=8, a=8'hC5, b=8'h3A, ops 0..7, rsp_ready=1 → rsp_data = 00, FF, 3A, FF, FF, 00, 00, C5. rsp_id=0 for each, one cycle after accept.
- Round-robin, all 4 valid continuously, rsp_ready=1 → rsp_id sequence 0,1,2,3,0,1. Then req_valid=4'b1010 with ptr=2 → grant 3, then 1, then 3.
- Backpressure, rsp_ready=0 for 5 cycles while FULL with id=2, data=8'h5A → outputs stable, req_ready=0 throughout. Raise rsp_ready with requester 1 pending → same-edge reload, rsp_id=1, rsp_valid continuously 1.
- Exhaustive 1-bit check with W=1, every requester/op/a/b combination → rsp_data matches the bitwise expression. grant_cnt equals the number of accepts.
- Saturation, force 70000 accepts → grant_cnt stops at 16'hFFFF and does not wrap.

Source files
------------

// File: rtl/mux_gate_arbiter.sv
// mux_gate_arbiter: N_REQ requesters time-share one logic unit built only
// from 2:1 muxes, arbitrated round-robin, with one registered response.
//
// Ports:
//   clk, rst_n           clock and async active-low reset
//   req_valid/req_ready  per-requester handshake (ready is one-hot or zero)
//   req_op/req_a/req_b   packed per-requester opcode and operands
//   rsp_valid/rsp_ready  response handshake
//   rsp_id/rsp_data      requester index and result held in the register
//   grant_cnt            saturating count of accepted requests

module mgu_mux2 (
    input  logic i_s,
    input  logic i_d0,
    input  logic i_d1,
    output logic o_y
);
    assign o_y = i_s ? i_d1 : i_d0;
endmodule

module mgu_gate_bit (
    input  logic [2:0] i_op,
    input  logic       i_a,
    input  logic       i_b,
    output logic       o_y
);
    logic w_na, w_nb, w_and, w_or, w_xor;
    logic w_nand, w_nor, w_xnor, w_buf;
    logic w_s01, w_s23, w_s45, w_s67, w_s03, w_s47;

    // every gate is a mux with a or b on the select line
    mgu_mux2 u_na   (.i_s(i_a),    .i_d0(1'b1), .i_d1(1'b0), .o_y(w_na));
    mgu_mux2 u_nb   (.i_s(i_b),    .i_d0(1'b1), .i_d1(1'b0), .o_y(w_nb));
    mgu_mux2 u_and  (.i_s(i_a),    .i_d0(1'b0), .i_d1(i_b),  .o_y(w_and));
    mgu_mux2 u_or   (.i_s(i_a),    .i_d0(i_b),  .i_d1(1'b1), .o_y(w_or));
    mgu_mux2 u_xor  (.i_s(i_a),    .i_d0(i_b),  .i_d1(w_nb), .o_y(w_xor));
    mgu_mux2 u_nand (.i_s(w_and),  .i_d0(1'b1), .i_d1(1'b0), .o_y(w_nand));
    mgu_mux2 u_nor  (.i_s(w_or),   .i_d0(1'b1), .i_d1(1'b0), .o_y(w_nor));
    mgu_mux2 u_xnor (.i_s(w_xor),  .i_d0(1'b1), .i_d1(1'b0), .o_y(w_xnor));
    mgu_mux2 u_buf  (.i_s(i_a),    .i_d0(1'b0), .i_d1(1'b1), .o_y(w_buf));

    // 8:1 opcode select as a three-level mux tree
    mgu_mux2 u_s01 (.i_s(i_op[0]), .i_d0(w_and),  .i_d1(w_or),  .o_y(w_s01));
    mgu_mux2 u_s23 (.i_s(i_op[0]), .i_d0(w_na),   .i_d1(w_xor), .o_y(w_s23));
    mgu_mux2 u_s45 (.i_s(i_op[0]), .i_d0(w_nand), .i_d1(w_nor), .o_y(w_s45));
    mgu_mux2 u_s67 (.i_s(i_op[0]), .i_d0(w_xnor), .i_d1(w_buf), .o_y(w_s67));
    mgu_mux2 u_s03 (.i_s(i_op[1]), .i_d0(w_s01),  .i_d1(w_s23), .o_y(w_s03));
    mgu_mux2 u_s47 (.i_s(i_op[1]), .i_d0(w_s45),  .i_d1(w_s67), .o_y(w_s47));
    mgu_mux2 u_out (.i_s(i_op[2]), .i_d0(w_s03),  .i_d1(w_s47), .o_y(o_y));
endmodule

module mgu_gate_unit #(
    parameter int W = 8
) (
    input  logic [2:0]   i_op,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_y
);
    for (genvar g = 0; g < W; g++) begin : g_bit
        mgu_gate_bit u_bit (
            .i_op(i_op),
            .i_a (i_a[g]),
            .i_b (i_b[g]),
            .o_y (o_y[g])
        );
    end
endmodule

module mux_gate_arbiter #(
    parameter  int N_REQ = 4,
    parameter  int W     = 8,
    localparam int IDW   = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [3*N_REQ-1:0] req_op,
    input  logic [W*N_REQ-1:0] req_a,
    input  logic [W*N_REQ-1:0] req_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [W-1:0]       rsp_data,
    output logic [15:0]        grant_cnt
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t         r_state, w_state_nxt;
    logic [IDW-1:0] r_ptr, r_id;
    logic [W-1:0]   r_data;
    logic [15:0]    r_cnt;

    logic           w_can_accept, w_found, w_accept;
    logic [IDW-1:0] w_gnt;
    logic [2:0]     w_op;
    logic [W-1:0]   w_a, w_b, w_y;

    // Two descending passes: the first leaves the lowest valid index
    // overall (the wrap-around winner), the second overrides it with the
    // lowest valid index at or above the pointer when one exists.
    always_comb begin
        w_found      = 1'b0;
        w_gnt        = '0;
        req_ready    = '0;
        w_can_accept = (r_state == EMPTY) || rsp_ready;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (req_valid[j]) begin
                w_found = 1'b1;
                w_gnt   = IDW'(j);
            end
        end
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (req_valid[j] && j >= int'(r_ptr)) begin
                w_gnt = IDW'(j);
            end
        end
        w_accept = w_found && w_can_accept;
        if (w_accept) begin
            req_ready[w_gnt] = 1'b1;
        end
    end

    // payload only feeds data, never the ready path
    assign w_op = req_op[3*int'(w_gnt) +: 3];
    assign w_a  = req_a[W*int'(w_gnt) +: W];
    assign w_b  = req_b[W*int'(w_gnt) +: W];

    mgu_gate_unit #(.W(W)) u_gate (
        .i_op(w_op),
        .i_a (w_a),
        .i_b (w_b),
        .o_y (w_y)
    );

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            EMPTY: if (w_accept) w_state_nxt = FULL;
            FULL:  if (rsp_ready && !w_accept) w_state_nxt = EMPTY;
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr  <= '0;
            r_id   <= '0;
            r_data <= '0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_id   <= w_gnt;
            r_data <= w_y;
            r_ptr  <= (w_gnt == IDW'(N_REQ - 1)) ? '0 : w_gnt + 1'b1;
            if (r_cnt != 16'hFFFF) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    assign rsp_valid = (r_state == FULL);
    assign rsp_id    = r_id;
    assign rsp_data  = r_data;
    assign grant_cnt = r_cnt;
endmodule

// File: tb/tb_mux_gate_arbiter.sv
// tb_mux_gate_arbiter: vector tables, directed corner sequences and
// random traffic against a behavioural model; W=8 and W=1 instances.

module tb_mux_gate_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [N-1:0]   a_valid, a_ready;
    logic [3*N-1:0] a_op;
    logic [8*N-1:0] a_a, a_b;
    logic           a_rsp_valid, a_rsp_ready;
    logic [1:0]     a_rsp_id;
    logic [7:0]     a_rsp_data;
    logic [15:0]    a_cnt;

    logic [N-1:0]   b_valid, b_ready;
    logic [3*N-1:0] b_op;
    logic [N-1:0]   b_a, b_b;
    logic           b_rsp_valid, b_rsp_ready;
    logic [1:0]     b_rsp_id;
    logic [0:0]     b_rsp_data;
    logic [15:0]    b_cnt;

    mux_gate_arbiter #(.N_REQ(N), .W(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(a_valid), .req_ready(a_ready),
        .req_op(a_op), .req_a(a_a), .req_b(a_b),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
        .rsp_id(a_rsp_id), .rsp_data(a_rsp_data), .grant_cnt(a_cnt)
    );

    mux_gate_arbiter #(.N_REQ(N), .W(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_valid), .req_ready(b_ready),
        .req_op(b_op), .req_a(b_a), .req_b(b_b),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_id(b_rsp_id), .rsp_data(b_rsp_data), .grant_cnt(b_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    int         m_ptr, m_id, m_cnt;
    bit         m_full;
    logic [7:0] m_data;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;

    function automatic logic [7:0] ref_op(input logic [2:0] op,
                                          input logic [7:0] a,
                                          input logic [7:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return ~a;
            3'd3:    return a ^ b;
            3'd4:    return ~(a & b);
            3'd5:    return ~(a | b);
            3'd6:    return ~(a ^ b);
            default: return a;
        endcase
    endfunction

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int i = 0; i < N; i++) begin
            if (v[(ptr + i) % N]) return (ptr + i) % N;
        end
        return -1;
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_id   = 0;
        m_cnt  = 0;
        m_full = 0;
        m_data = '0;
    endtask

    // one clock on instance A: entered and left just after a negedge
    task automatic cyc_a(output int acc);
        int         k;
        logic [N-1:0] er;
        k   = pick(a_valid, m_ptr);
        er  = '0;
        acc = -1;
        if (k >= 0 && (!m_full || a_rsp_ready)) begin
            er[k] = 1'b1;
            acc   = k;
        end
        #1;
        check("req_ready", a_ready, er);
        @(posedge clk);
        if (acc >= 0) begin
            m_full = 1;
            m_id   = acc;
            m_data = ref_op(a_op[3*acc +: 3], a_a[8*acc +: 8],
                            a_b[8*acc +: 8]);
            m_ptr  = (acc + 1) % N;
            if (m_cnt < 65535) m_cnt++;
        end else if (m_full && a_rsp_ready) begin
            m_full = 0;
        end
        #1;
        check("rsp_valid", a_rsp_valid, m_full);
        check("rsp_id", a_rsp_id, m_id);
        check("rsp_data", a_rsp_data, m_data);
        check("grant_cnt", a_cnt, m_cnt);
        @(negedge clk);
    endtask

    initial begin
        int   acc;
        int   b_exp_cnt;
        vec_t tbl [8];
        int   rr_exp [9];
        logic [7:0] e8;

        tbl[0] = '{3'd0, 8'hC5, 8'h3A, 8'h00};
        tbl[1] = '{3'd1, 8'hC5, 8'h3A, 8'hFF};
        tbl[2] = '{3'd2, 8'hC5, 8'h3A, 8'h3A};
        tbl[3] = '{3'd3, 8'hC5, 8'h3A, 8'hFF};
        tbl[4] = '{3'd4, 8'hC5, 8'h3A, 8'hFF};
        tbl[5] = '{3'd5, 8'hC5, 8'h3A, 8'h00};
        tbl[6] = '{3'd6, 8'hC5, 8'h3A, 8'h00};
        tbl[7] = '{3'd7, 8'hC5, 8'h3A, 8'hC5};
        rr_exp = '{0, 1, 2, 3, 0, 1, 3, 1, 3};

        rst_n       = 1'b0;
        a_valid     = '0;
        a_op        = '0;
        a_a         = '0;
        a_b         = '0;
        a_rsp_ready = 1'b1;
        b_valid     = '0;
        b_op        = '0;
        b_a         = '0;
        b_b         = '0;
        b_rsp_ready = 1'b1;
        model_reset();

        repeat (3) @(negedge clk);
        check("rst_valid", a_rsp_valid, 0);
        check("rst_data", a_rsp_data, 0);
        check("rst_id", a_rsp_id, 0);
        check("rst_cnt", a_cnt, 0);
        check("rst_ready", a_ready, 0);
        check("rst_b_cnt", b_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // round robin: all four, then 4'b1010 from ptr=2
        a_op    = 12'($urandom);
        a_a     = $urandom;
        a_b     = $urandom;
        a_valid = 4'b1111;
        for (int i = 0; i < 9; i++) begin
            if (i == 6) a_valid = 4'b1010;
            cyc_a(acc);
            check("rr_id", a_rsp_id, rr_exp[i]);
        end

        // backpressure while FULL with id 2 / 5A
        a_valid       = 4'b0100;
        a_op[8:6]     = 3'd7;
        a_a[23:16]    = 8'h5A;
        cyc_a(acc);
        a_valid       = 4'b0010;
        a_op[5:3]     = 3'd0;
        a_a[15:8]     = 8'hF0;
        a_b[15:8]     = 8'h3C;
        a_rsp_ready   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc_a(acc);
            check("bp_ready", a_ready, 0);
            check("bp_valid", a_rsp_valid, 1);
            check("bp_id", a_rsp_id, 2);
            check("bp_data", a_rsp_data, 8'h5A);
        end
        a_rsp_ready = 1'b1;
        cyc_a(acc);
        check("reload_valid", a_rsp_valid, 1);
        check("reload_id", a_rsp_id, 1);
        check("reload_data", a_rsp_data, 8'h30);
        a_valid = '0;

        // opcode sweep on requester 0
        for (int i = 0; i < 8; i++) begin
            a_valid   = 4'b0001;
            a_op[2:0] = tbl[i].op;
            a_a[7:0]  = tbl[i].a;
            a_b[7:0]  = tbl[i].b;
            cyc_a(acc);
            check("sweep_data", a_rsp_data, tbl[i].exp);
            check("sweep_id", a_rsp_id, 0);
        end
        a_valid = '0;
        cyc_a(acc);
        check("drain_valid", a_rsp_valid, 0);
        check("drain_hold", a_rsp_data, 8'hC5);

        // random traffic honouring hold-until-ready
        for (int c = 0; c < 400; c++) begin
            for (int r = 0; r < N; r++) begin
                if (!a_valid[r] && $urandom_range(0, 1) == 1) begin
                    a_valid[r]      = 1'b1;
                    a_op[3*r +: 3]  = 3'($urandom);
                    a_a[8*r +: 8]   = 8'($urandom);
                    a_b[8*r +: 8]   = 8'($urandom);
                end
            end
            a_rsp_ready = ($urandom_range(0, 3) != 0);
            cyc_a(acc);
            if (acc >= 0) a_valid[acc] = 1'b0;
        end

        // asynchronous reset while FULL
        a_valid     = 4'b0001;
        a_rsp_ready = 1'b0;
        cyc_a(acc);
        check("pre_rst_full", a_rsp_valid, 1);
        a_valid = '0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", a_rsp_valid, 0);
        check("async_rst_cnt", a_cnt, 0);
        model_reset();
        a_rsp_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_valid", a_rsp_valid, 0);

        // exhaustive W=1: requester x op x a x b
        b_exp_cnt = 0;
        for (int r = 0; r < N; r++) begin
            for (int o = 0; o < 8; o++) begin
                for (int ab = 0; ab < 4; ab++) begin
                    b_valid        = '0;
                    b_valid[r]     = 1'b1;
                    b_op[3*r +: 3] = 3'(o);
                    b_a[r]         = ab[1];
                    b_b[r]         = ab[0];
                    @(posedge clk);
                    #1;
                    b_exp_cnt++;
                    e8 = ref_op(3'(o), {7'b0, ab[1]}, {7'b0, ab[0]});
                    check("w1_data", b_rsp_data, e8[0]);
                    check("w1_id", b_rsp_id, r);
                    @(negedge clk);
                end
            end
        end
        check("w1_cnt", b_cnt, b_exp_cnt);

        // saturation: 70000 accepts in total
        b_valid = 4'b1111;
        repeat (65534 - b_exp_cnt) @(posedge clk);
        #1;
        check("sat_fffe", b_cnt, 16'hFFFE);
        @(posedge clk);
        #1;
        check("sat_ffff", b_cnt, 16'hFFFF);
        repeat (70000 - 65535) @(posedge clk);
        #1;
        check("sat_hold", b_cnt, 16'hFFFF);
        check("sat_valid", b_rsp_valid, 1);
        b_valid = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
